hilo_muldiv_unit: RTL and testbench



---
 rtl/hilo_pkg.sv | 21 ++
 rtl/muldiv_iter_datapath.sv | 96 +++++++++
 rtl/hilo_muldiv_unit.sv | 129 ++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// controller states and the default operand width.
package hilo_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        DIV   = 2'd2,
        FIXUP = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_iter_datapath.sv
// Iterative shift-add multiplier / restoring divider over operand magnitudes,
// with sign fix-up applied combinationally to the finished result.
module muldiv_iter_datapath
    import hilo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             is_div_i,
    input  logic             is_signed_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_res_o,
    output logic [WIDTH-1:0] lo_res_o,
    output logic             dz_o
);

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    // {upper, lower} holds {accumulator, multiplier} for MUL and
    // {partial remainder, dividend/quotient} for DIV.
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   opnd_q;
    logic               is_div_q, q_neg_q, r_neg_q, dz_q;

    logic [WIDTH:0]     add_sum, sub_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix;

    assign a_neg = is_signed_i && a_i[WIDTH-1];
    assign b_neg = is_signed_i && b_i[WIDTH-1];
    assign a_mag = a_neg ? -a_i : a_i;
    assign b_mag = b_neg ? -b_i : b_i;

    assign add_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    assign sub_diff = prod_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};

    always_comb begin
        prod_d = prod_q;
        if (load_i) begin
            prod_d = {{WIDTH{1'b0}}, (is_div_i ? a_mag : b_mag)};
        end else if (step_i) begin
            if (is_div_q) begin
                // Bit WIDTH of the difference is the borrow: set means restore.
                if (!sub_diff[WIDTH]) begin
                    prod_d = {sub_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
                end else begin
                    prod_d = {prod_q[2*WIDTH-2:0], 1'b0};
                end
            end else begin
                if (prod_q[0]) begin
                    prod_d = {add_sum, prod_q[WIDTH-1:1]};
                end else begin
                    prod_d = {1'b0, prod_q[2*WIDTH-1:1]};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q   <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            prod_q <= prod_d;
            if (load_i) begin
                opnd_q   <= is_div_i ? b_mag : a_mag;
                is_div_q <= is_div_i;
                q_neg_q  <= a_neg ^ b_neg;
                r_neg_q  <= a_neg;
                dz_q     <= is_div_i && (b_i == '0);
            end
        end
    end

    // With a zero divisor every step succeeds, so the remainder ends up as the
    // dividend magnitude and re-signing restores rs_value; only LO is forced.
    assign quo      = prod_q[WIDTH-1:0];
    assign rem      = prod_q[2*WIDTH-1:WIDTH];
    assign quo_fix  = dz_q ? '1 : (q_neg_q ? -quo : quo);
    assign rem_fix  = r_neg_q ? -rem : rem;
    assign prod_fix = q_neg_q ? -prod_q : prod_q;

    assign hi_res_o = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign lo_res_o = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
    assign dz_o     = dz_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner: sequences multi-cycle MULT/DIV through the iterative datapath
// and applies MTHI/MTLO writes; flush squashes an in-flight op.
//   state | meaning
//   IDLE  | ready; accepts mul/div/MTHI/MTLO
//   MUL   | WIDTH shift-add iterations
//   DIV   | WIDTH restoring-divide iterations
//   FIXUP | sign correction; HI/LO written on exit
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEFAULT,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_value,
    input  logic [WIDTH-1:0] rt_value,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d, dbz_q, dbz_d;

    logic             accept, is_muldiv_op, is_div_op, is_signed_op;
    logic [WIDTH-1:0] dp_hi, dp_lo;
    logic             dp_dz;

    assign accept       = (state_q == IDLE) && start && !flush;
    assign is_div_op    = (op == OP_DIV) || (op == OP_DIVU);
    assign is_muldiv_op = (op == OP_MULT) || (op == OP_MULTU) || is_div_op;
    assign is_signed_op = (op == OP_MULT) || (op == OP_DIV);

    muldiv_iter_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk        (clk),
        .rst        (reset),
        .load_i     (accept && is_muldiv_op),
        .is_div_i   (is_div_op),
        .is_signed_i(is_signed_op),
        .step_i     ((state_q == MUL) || (state_q == DIV)),
        .a_i        (rs_value),
        .b_i        (rt_value),
        .hi_res_o   (dp_hi),
        .lo_res_o   (dp_lo),
        .dz_o       (dp_dz)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_d = MUL;
                            cnt_d   = CNT_W'(WIDTH);
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = DIV;
                            cnt_d   = CNT_W'(WIDTH);
                        end
                        OP_MTHI: hi_d = rs_value;
                        OP_MTLO: lo_d = rs_value;
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = FIXUP;
                    end
                end
            end
            FIXUP: begin
                state_d = IDLE;
                if (!flush) begin
                    hi_d   = dp_hi;
                    lo_d   = dp_lo;
                    done_d = 1'b1;
                    dbz_d  = dp_dz;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit at WIDTH=32 and WIDTH=8 against an
// arithmetic reference model.
module tb_hilo_muldiv_unit;
    import hilo_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start32, flush32, busy32, done32, dbz32;
    logic [2:0]  op32;
    logic [31:0] rs32, rt32, hi32, lo32;

    logic        start8, flush8, busy8, done8, dbz8;
    logic [2:0]  op8;
    logic [7:0]  rs8, rt8, hi8, lo8;

    hilo_muldiv_unit #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32),
        .rs_value(rs32), .rt_value(rt32), .flush(flush32),
        .busy(busy32), .done(done32), .div_by_zero(dbz32), .hi(hi32), .lo(lo32)
    );

    hilo_muldiv_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8),
        .rs_value(rs8), .rt_value(rt8), .flush(flush8),
        .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    res_t        exp32_q[$];
    res_t        exp8_q[$];
    res_t        e32, e8;
    logic [31:0] m_hi, m_lo;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic res_t model(input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] b, input int w);
        res_t   r;
        longint mask, ua, ub, sa, sb, p;
        r    = '0;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = ua[w-1] ? ua - (longint'(1) << w) : ua;
        sb   = ub[w-1] ? ub - (longint'(1) << w) : ub;
        case (o)
            OP_MULT: begin
                p    = sa * sb;
                r.hi = 32'((p >>> w) & mask);
                r.lo = 32'(p & mask);
            end
            OP_MULTU: begin
                p    = ua * ub;
                r.hi = 32'((p >> w) & mask);
                r.lo = 32'(p & mask);
            end
            default: begin
                if (ub == 0) begin
                    r.hi = 32'(ua);
                    r.lo = 32'(mask);
                    r.dz = 1'b1;
                end else if (o == OP_DIV) begin
                    r.lo = 32'((sa / sb) & mask);
                    r.hi = 32'((sa % sb) & mask);
                end else begin
                    r.lo = 32'((ua / ub) & mask);
                    r.hi = 32'((ua % ub) & mask);
                end
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] mask;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1 << (w - 1);
            2:       return mask;
            3:       return 32'($urandom_range(1, 10));
            default: return $urandom & mask;
        endcase
    endfunction

    // Scoreboard monitors: a result is popped whenever done is presented.
    always @(negedge clk) begin
        if (!reset) begin
            if (done32) begin
                if (exp32_q.size() == 0) begin
                    chk("done32_unexpected", 64'(done32), 64'(0));
                end else begin
                    e32 = exp32_q.pop_front();
                    chk("hi32", 64'(hi32), 64'(e32.hi));
                    chk("lo32", 64'(lo32), 64'(e32.lo));
                    chk("dbz32", 64'(dbz32), 64'(e32.dz));
                end
            end else begin
                chk("dbz32_without_done", 64'(dbz32), 64'(0));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (done8) begin
                if (exp8_q.size() == 0) begin
                    chk("done8_unexpected", 64'(done8), 64'(0));
                end else begin
                    e8 = exp8_q.pop_front();
                    chk("hi8", 64'(hi8), 64'(e8.hi));
                    chk("lo8", 64'(lo8), 64'(e8.lo));
                    chk("dbz8", 64'(dbz8), 64'(e8.dz));
                end
            end
        end
    end

    task automatic wait_idle32();
        int n = 0;
        while (busy32 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy32) chk("idle32_timeout", 64'(busy32), 64'(0));
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (busy8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy8) chk("idle8_timeout", 64'(busy8), 64'(0));
    endtask

    // Called at a negedge; returns at the negedge after the issuing edge.
    task automatic issue32(input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input bit track);
        res_t r;
        wait_idle32();
        start32 = 1'b1; op32 = o; rs32 = a; rt32 = b;
        @(negedge clk);
        start32 = 1'b0;
        if (o <= OP_DIVU) begin
            chk("busy32_after_accept", 64'(busy32), 64'(1));
            if (track) begin
                r = model(o, a, b, 32);
                exp32_q.push_back(r);
                m_hi = r.hi;
                m_lo = r.lo;
            end
        end else begin
            if (o == OP_MTHI) m_hi = a;
            if (o == OP_MTLO) m_lo = a;
            chk("busy32_mt_nop", 64'(busy32), 64'(0));
            chk("hi32_mt_nop", 64'(hi32), 64'(m_hi));
            chk("lo32_mt_nop", 64'(lo32), 64'(m_lo));
        end
    endtask

    task automatic issue8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        wait_idle8();
        start8 = 1'b1; op8 = o; rs8 = a; rt8 = b;
        @(negedge clk);
        start8 = 1'b0;
        exp8_q.push_back(model(o, 32'(a), 32'(b), 8));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        logic [31:0] old_hi;
        logic [2:0]  o;

        reset = 1'b1;
        start32 = 0; flush32 = 0; op32 = 0; rs32 = 0; rt32 = 0;
        start8  = 0; flush8  = 0; op8  = 0; rs8  = 0; rt8  = 0;
        m_hi = 0; m_lo = 0;
        repeat (2) @(negedge clk);
        chk("rst_hi32", 64'(hi32), 64'(0));
        chk("rst_lo32", 64'(lo32), 64'(0));
        chk("rst_busy32", 64'(busy32), 64'(0));
        chk("rst_done32", 64'(done32), 64'(0));
        chk("rst_dbz32", 64'(dbz32), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // MULT 7 x -3: busy exactly WIDTH+1 cycles, done for one cycle.
        issue32(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b1);
        cnt = 0;
        while (busy32 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("mult_busy_cycles", 64'(cnt), 64'(33));
        chk("mult_done_pulse", 64'(done32), 64'(1));
        chk("mult_hi", 64'(hi32), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo32), 64'hFFFF_FFEB);
        @(negedge clk);
        chk("mult_done_one_cycle", 64'(done32), 64'(0));

        issue32(OP_DIVU, 32'd100, 32'd7, 1'b1);
        wait_idle32();
        chk("divu_lo", 64'(lo32), 64'(14));
        chk("divu_hi", 64'(hi32), 64'(2));
        issue32(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_idle32();
        chk("div_neg_lo", 64'(lo32), 64'hFFFF_FFFD);
        chk("div_neg_hi", 64'(hi32), 64'hFFFF_FFFF);

        issue32(OP_DIVU, 32'h1234, 32'd0, 1'b1);
        wait_idle32();
        chk("dz_lo", 64'(lo32), 64'hFFFF_FFFF);
        chk("dz_hi", 64'(hi32), 64'h1234);
        issue32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_idle32();
        chk("ovf_lo", 64'(lo32), 64'h8000_0000);
        chk("ovf_hi", 64'(hi32), 64'(0));

        // MTHI/MTLO back-to-back, then no-op encoding.
        issue32(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1);
        issue32(OP_MTLO, 32'h0BAD_F00D, 32'd0, 1'b1);
        chk("mthi_value", 64'(hi32), 64'hDEAD_BEEF);
        issue32(3'd6, 32'h1111_2222, 32'd0, 1'b1);
        issue32(3'd7, 32'h3333_4444, 32'd0, 1'b1);

        // MTHI while a MULT is busy is dropped.
        old_hi = m_hi;
        issue32(OP_MULT, 32'd1234, 32'd5678, 1'b1);
        repeat (3) @(negedge clk);
        start32 = 1'b1; op32 = OP_MTHI; rs32 = 32'h5555_5555;
        @(negedge clk);
        start32 = 1'b0;
        chk("mthi_while_busy", 64'(hi32), 64'(old_hi));
        wait_idle32();
        chk("hi_after_busy_mthi", 64'(hi32), 64'(m_hi));

        // flush in IDLE blocks a same-cycle start.
        flush32 = 1'b1; start32 = 1'b1; op32 = OP_MTHI; rs32 = 32'h7777_7777;
        @(negedge clk);
        op32 = OP_MULT;
        @(negedge clk);
        flush32 = 1'b0; start32 = 1'b0;
        chk("flush_idle_hi", 64'(hi32), 64'(m_hi));
        chk("flush_idle_busy", 64'(busy32), 64'(0));

        // Flush at cycle 10 of a MULTU.
        issue32(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        repeat (9) @(negedge clk);
        flush32 = 1'b1;
        @(negedge clk);
        flush32 = 1'b0;
        chk("flush_busy_drop", 64'(busy32), 64'(0));
        repeat (40) @(negedge clk);
        chk("flush_hi_kept", 64'(hi32), 64'(m_hi));
        chk("flush_lo_kept", 64'(lo32), 64'(m_lo));
        issue32(OP_MULTU, 32'd3, 32'd5, 1'b1);
        wait_idle32();
        chk("multu_3x5_hi", 64'(hi32), 64'(0));
        chk("multu_3x5_lo", 64'(lo32), 64'(15));

        // WIDTH=8: MULT 0x80 x 0x80, 9 busy cycles.
        issue8(OP_MULT, 8'h80, 8'h80);
        cnt = 0;
        while (busy8 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("w8_busy_cycles", 64'(cnt), 64'(9));
        chk("w8_hi", 64'(hi8), 64'h40);
        chk("w8_lo", 64'(lo8), 64'h00);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            issue32(o, pick(32), pick(32), 1'b1);
        end
        wait_idle32();
        for (int i = 0; i < 30; i++) begin
            issue8(3'($urandom_range(0, 3)), 8'(pick(8)), 8'(pick(8)));
        end
        wait_idle8();
        @(negedge clk);

        // Asynchronous reset in the middle of a DIV.
        issue32(OP_DIV, 32'h1234_5678, 32'd3, 1'b0);
        repeat (5) @(negedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_hi", 64'(hi32), 64'(0));
        chk("arst_lo", 64'(lo32), 64'(0));
        chk("arst_busy", 64'(busy32), 64'(0));
        m_hi = 0; m_lo = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue32(OP_DIVU, 32'd1000, 32'd10, 1'b1);
        wait_idle32();
        chk("post_rst_lo", 64'(lo32), 64'(100));
        @(negedge clk);

        chk("sb32_drained", 64'(exp32_q.size()), 64'(0));
        chk("sb8_drained", 64'(exp8_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
